gpo_serialiser: RTL
===================

# gpo_serialiser

Serial output driver that sits directly downstream of the GPIO block's parallel output register. It watches a parallel word and, whenever the word changes, shifts it out MSB-first to a chain of external 74HC595-style shift/latch registers (LEDs, 7-segment displays). A transfer is a bit-banged serial-clock/data/latch sequence paced by a clock divider. Each update is atomic: the external outputs change only on the final latch pulse.

## Interface
- `Width`, default 16: number of bits shifted per transfer; legal range ≥ 2.
- `ClkDiv`, default 4: `clk_i` cycles per half-period of `sclk_o`, and the length of the latch pulse; legal range ≥ 1.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `data_i`  in  `Width`  parallel word to mirror; normally the GPIO output register.
- `force_i`  in  1  single-cycle pulse requesting a retransmit even when `data_i` has not changed.
- `sclk_o`  out  1  serial shift clock; external register samples on the rising edge.
- `sdo_o`  out  1  serial data.
- `latch_o`  out  1  storage-register latch; high pulse.
- `busy_o`  out  1  high while a transfer is in progress.

## Operation
- All outputs are registered.
- Reset values: `sclk_o`, `sdo_o`, `latch_o` and `busy_o` = 0; shadow register = 0; `pending` = 1. The pending flag forces one all-zero-equivalent transfer of the current `data_i` after reset.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - **IDLE:** start when `pending` is set or `data_i != shadow`. On start, in the same cycle:
    - capture `data_i` into the shift register and the shadow register;
    - clear `pending`;
    - set `bit_cnt` = 0 and `div_cnt` = 0;
    - set `sdo_o` <= `data_i[Width-1]` and `busy_o` <= 1;
    - go to SHIFT_LO.
  - **SHIFT_LO:** `sclk_o` = 0 for `ClkDiv` cycles, then go to SHIFT_HI.
  - **SHIFT_HI:** `sclk_o` = 1 for `ClkDiv` cycles. At the end:
    - if `bit_cnt == Width-1`: go to LATCH, with `sclk_o` <= 0 and `sdo_o` <= 0;
    - otherwise: increment `bit_cnt`, shift left by one, set `sdo_o` to the next bit, and go to SHIFT_LO.
    - `sdo_o` therefore changes only on the falling edge of `sclk_o`, never while it is high.
  - **LATCH:** `latch_o` = 1 for `ClkDiv` cycles. It then drops to 0, `busy_o` drops to 0, and the FSM returns to IDLE.
- `div_cnt` counts 0 to `ClkDiv-1` and wraps on each phase change. `bit_cnt` is `$clog2(Width)` bits wide.
- `data_i` changes during a transfer are ignored by the shift register. After returning to IDLE, the shadow comparison triggers a fresh transfer carrying the latest value; intermediate values may be skipped.
- `force_i` in any state sets `pending`. Multiple pulses during one transfer collapse into a single retransmit.
- A `force_i` pulse in the same IDLE cycle as a start is absorbed by that start. No extra transfer results.
- Reset asserted mid-transfer: outputs go low immediately and `pending` = 1. The external register keeps its old latched value until the post-reset transfer completes.

## Timing
- Start to first `sdo_o` valid: 1 cycle, i.e. the registered output in the cycle after the IDLE decision.
- Per bit: 2×`ClkDiv` cycles. The first rising edge of `sclk_o` occurs `ClkDiv` cycles after `sdo_o` becomes valid.
- `busy_o` is high for exactly 2×`ClkDiv`×`Width` + `ClkDiv` cycles. With defaults this is 132 cycles.
- The minimum IDLE gap between back-to-back transfers is 1 cycle, in which `busy_o` = 0.
- `latch_o` and `sclk_o` are never high at the same time.

## Test plan
- **Reset start-up** (`Width`=16, `ClkDiv`=4): release reset with `data_i`=16'h0000 → one transfer with `busy_o` high for 132 cycles, 16 `sclk_o` rising edges all sampling 0, and one 4-cycle `latch_o` pulse. After that, no activity while `data_i` is stable.
- **Bit order and setup:** set `data_i`=16'hA5C3 → bits sampled on the `sclk_o` rising edges read 1010_0101_1100_0011 (MSB first). `sdo_o` is stable throughout every `sclk_o`-high phase.
- **Change mid-transfer:** start with 16'h0001, change to 16'h8000 and then 16'hFFFF during shifting → the first transfer completes with 16'h0001. After a 1-cycle IDLE gap, exactly one more transfer carries 16'hFFFF.
- **Force collapse:** 3 `force_i` pulses during a transfer with `data_i` unchanged → exactly one retransmit of the same value follows. A `force_i` pulse in IDLE alone → one transfer.
- **Reset mid-transfer:** assert `rst_ni` low at bit 7 → `sclk_o`, `sdo_o`, `latch_o` and `busy_o` go 0 asynchronously with no latch pulse. After release, a full transfer of the current `data_i` is sent.
- **Minimum divider** (`ClkDiv`=1, `Width`=2): `data_i`=2'b10 → `busy_o` high for 5 cycles, `sclk_o` pattern 0,1,0,1, then `latch_o` high for 1 cycle.

Source files
------------

// File: rtl/gpo_serialiser_if.sv
// Parallel word in, bit-banged 74HC595 serial/latch signals out.
// The serialiser drives through "master"; the word source or observer uses "slave".
interface gpo_serialiser_if #(
  parameter int Width = 16
);
  logic [Width-1:0] data_i;
  logic             force_i;
  logic             sclk_o;
  logic             sdo_o;
  logic             latch_o;
  logic             busy_o;

  modport master (
    input  data_i, force_i,
    output sclk_o, sdo_o, latch_o, busy_o
  );

  modport slave (
    output data_i, force_i,
    input  sclk_o, sdo_o, latch_o, busy_o
  );
endinterface

// File: rtl/gpo_serialiser.sv
// Mirrors a parallel word onto an external shift/latch register chain, MSB first,
// retransmitting whenever the word changes or a retransmit is forced.
//
// state    | meaning
// IDLE     | waiting for a word change or a pending retransmit
// SHIFT_LO | sclk low phase; sdo holds the current bit
// SHIFT_HI | sclk high phase; external register samples on entry
// LATCH    | latch pulse; the new word becomes visible externally
module gpo_serialiser #(
  parameter int Width  = 16,
  parameter int ClkDiv = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  gpo_serialiser_if.master bus
);
  localparam int BitW = $clog2(Width);
  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(Width - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           r_state;
  logic [Width-2:0] r_shift;
  logic [Width-1:0] r_shadow;
  logic             r_pending;
  logic [BitW-1:0]  r_bit_cnt;
  logic [DivW-1:0]  r_div_cnt;
  logic             r_sclk;
  logic             r_sdo;
  logic             r_latch;
  logic             r_busy;

  logic w_div_end;
  logic w_start;

  assign w_div_end = (r_div_cnt == DivLast);
  assign w_start   = r_pending || (bus.data_i != r_shadow);

  // The MSB goes straight to sdo at start, so the shift register only keeps the rest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b1;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_sdo     <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (bus.force_i) r_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shift   <= bus.data_i[Width-2:0];
            r_shadow  <= bus.data_i;
            r_pending <= 1'b0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_sdo     <= bus.data_i[Width-1];
            r_busy    <= 1'b1;
            r_state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
            r_state   <= SHIFT_HI;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == BitLast) begin
              r_sdo   <= 1'b0;
              r_latch <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_sdo     <= r_shift[Width-2];
              r_shift   <= r_shift << 1;
              r_state   <= SHIFT_LO;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sclk_o  = r_sclk;
  assign bus.sdo_o   = r_sdo;
  assign bus.latch_o = r_latch;
  assign bus.busy_o  = r_busy;
endmodule
